sky130_fd_io__top_vrefcap_mon: RTL

- Clocked, parametrised monitor for the external reference capacitors on the vrefgen outputs.
- Supports NCH capacitor channels. Each channel has a cpos and a cneg terminal.
- Inputs are per-terminal "floating" indicators from the analog pad sense. The block filters them with per-terminal persistence counters and raises sticky, individually clearable fault flags, an interrupt and a saturating fault counter.
- Replaces the fixed-delay, simulation-only unconnected-terminal check with synthesizable, runtime-controlled detection.

---
 rtl/sky130_fd_io__top_vrefcap_mon.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sky130_fd_io__top_vrefcap_mon.sv
`default_nettype none
// ============================================================================
// Module   : sky130_fd_io__top_vrefcap_mon
// Purpose  : Runtime monitor for the external reference capacitors on the
//            vrefgen outputs. Each channel has a cpos and a cneg terminal.
//            Per-terminal "floating" indicators are filtered by persistence
//            counters. The filtered result raises sticky, write-1-clearable
//            fault flags, an interrupt and a saturating fault counter.
// Ports    : clk         - block clock, rising edge
//            rst_n       - synchronous active-low reset
//            en          - monitor enable; low disarms and restarts arm delay
//            filt_cycles - persistence threshold (0 behaves as 1)
//            cpos_float  - per-channel cpos floating indicator
//            cneg_float  - per-channel cneg floating indicator
//            clr_cpos    - write-1 clear of err_cpos bits
//            clr_cneg    - write-1 clear of err_cneg bits
//            armed       - arm delay has expired
//            err_cpos    - sticky cpos fault flags
//            err_cneg    - sticky cneg fault flags
//            irq         - OR of all fault flags
//            fault_cnt   - saturating count of flag rising events
// Revision : 1.0 - initial release
// ============================================================================
module sky130_fd_io__top_vrefcap_mon #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 8,
  parameter int ARM_DLY = 4,
  parameter int FCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  filt_cycles,
  input  logic [NCH-1:0]    cpos_float,
  input  logic [NCH-1:0]    cneg_float,
  input  logic [NCH-1:0]    clr_cpos,
  input  logic [NCH-1:0]    clr_cneg,
  output logic              armed,
  output logic [NCH-1:0]    err_cpos,
  output logic [NCH-1:0]    err_cneg,
  output logic              irq,
  output logic [FCNT_W-1:0] fault_cnt
);

  localparam int c_NT    = 2 * NCH;   // total terminals
  localparam int c_NR_W  = 5;         // holds 0..16 simultaneous rises
  localparam int c_SUM_W = FCNT_W + c_NR_W;
  localparam logic [7:0]         c_ARM_DLY = 8'(ARM_DLY);
  localparam logic [c_SUM_W-1:0] c_FMAX    = {{c_NR_W{1'b0}}, {FCNT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WATCH   = 2'd1,
    S_PENDING = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  // Terminal index map: [NCH-1:0] = cpos, [2*NCH-1:NCH] = cneg.
  logic [c_NT-1:0]    w_float;
  logic [c_NT-1:0]    w_clr;
  logic [c_NT-1:0]    w_err;
  logic [c_NT-1:0]    w_rise;
  logic [CNT_W-1:0]   w_n;
  logic               w_n1;
  logic [c_NR_W-1:0]  w_nrise;
  logic [c_SUM_W-1:0] w_sum;

  logic [7:0]         r_arm_cnt;
  logic               r_armed;
  logic [FCNT_W-1:0]  r_fcnt;

  assign w_float = {cneg_float, cpos_float};
  assign w_clr   = {clr_cneg, clr_cpos};
  assign w_n     = (filt_cycles == '0) ? CNT_W'(1) : filt_cycles;
  assign w_n1    = (w_n == CNT_W'(1));

  // Arm delay: counts enabled cycles; dropping en restarts it from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!en) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      r_arm_cnt <= r_arm_cnt + 8'd1;
      if (r_arm_cnt + 8'd1 == c_ARM_DLY) begin
        r_armed <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < c_NT; gi++) begin : g_term
    state_t           r_st;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [CNT_W:0]   w_inc;
    logic             w_set;

    // One extra bit so a count at the top of the range cannot wrap.
    assign w_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Set condition: the sample that completes N consecutive floating edges.
    // A clear taken while still floating counts as the first of those edges,
    // so with N=1 it re-sets immediately and the flag never drops.
    assign w_set = r_armed && w_float[gi] &&
                   (((r_st == S_WATCH) && w_n1) ||
                    ((r_st == S_PENDING) && (w_inc >= {1'b0, w_n})) ||
                    ((r_st == S_FAULT) && w_clr[gi] && w_n1));

    assign w_rise[gi] = w_set & ~r_err;
    assign w_err[gi]  = r_err;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_st  <= S_IDLE;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        // Set wins over a same-edge clear.
        r_err <= w_set | (r_err & ~w_clr[gi]);
        if (!r_armed) begin
          r_st  <= S_IDLE;
          r_cnt <= '0;
        end else begin
          case (r_st)
            S_IDLE: begin
              r_st  <= S_WATCH;
              r_cnt <= '0;
            end
            S_WATCH: begin
              if (w_float[gi]) begin
                r_cnt <= CNT_W'(1);
                r_st  <= w_n1 ? S_FAULT : S_PENDING;
              end else begin
                r_cnt <= '0;
              end
            end
            S_PENDING: begin
              if (!w_float[gi]) begin
                r_st  <= S_WATCH;
                r_cnt <= '0;
              end else begin
                r_cnt <= w_inc[CNT_W-1:0];
                if (w_inc >= {1'b0, w_n}) begin
                  r_st <= S_FAULT;
                end
              end
            end
            S_FAULT: begin
              if (w_clr[gi]) begin
                if (!w_float[gi]) begin
                  r_st  <= S_WATCH;
                  r_cnt <= '0;
                end else begin
                  r_cnt <= CNT_W'(1);
                  r_st  <= w_n1 ? S_FAULT : S_PENDING;
                end
              end
            end
            default: begin
              r_st  <= S_IDLE;
              r_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  // Number of flags rising on this edge.
  always_comb begin
    w_nrise = '0;
    for (int i = 0; i < c_NT; i++) begin
      w_nrise = w_nrise + {{(c_NR_W-1){1'b0}}, w_rise[i]};
    end
  end

  assign w_sum = {{c_NR_W{1'b0}}, r_fcnt} + {{(c_SUM_W-c_NR_W){1'b0}}, w_nrise};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcnt <= '0;
    end else if (w_sum > c_FMAX) begin
      r_fcnt <= {FCNT_W{1'b1}};
    end else begin
      r_fcnt <= w_sum[FCNT_W-1:0];
    end
  end

  assign armed     = r_armed;
  assign err_cpos  = w_err[NCH-1:0];
  assign err_cneg  = w_err[c_NT-1:NCH];
  assign irq       = |w_err;
  assign fault_cnt = r_fcnt;

endmodule
`default_nettype wire
